// File: rtl/my_divider_16.sv
// Sequential unsigned restoring divider: one trial subtraction per cycle.
// Quotient and remainder are ready WIDTH cycles after start; divide-by-zero finishes in one cycle.
module my_divider_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  // The partial remainder is always below the divisor, so it fits in WIDTH
  // bits between iterations; the extra bit lives only in the trial difference.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign shifted = {rem_q, shift_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    shift_d = shift_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            rem_d   = '0;
            shift_d = dividend;
            dvs_d   = divisor;
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            quot_d  = '1;
            remo_d  = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (!trial[WIDTH]) begin
          rem_d   = trial[WIDTH-1:0];
          shift_d = {shift_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d   = shifted[WIDTH-1:0];
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          quot_d  = shift_d;
          remo_d  = rem_d;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Handshake outputs are registered from the next state so they track state exactly.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      shift_q <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      shift_q <= shift_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_my_divider_16.sv
// Randomized bench for my_divider_16: an arithmetic reference model checked every cycle,
// plus literal expectations for the directed cases.
module tb_my_divider_16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  my_divider_16 dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: busy counts down the cycles left, results come from / and %.
  int          m_left;
  bit          m_done, m_dbz;
  logic [15:0] m_quo, m_rem, p_quo, p_rem;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left <= 0; m_done <= 0; m_dbz <= 0;
      m_quo <= '0; m_rem <= '0; p_quo <= '0; p_rem <= '0;
    end else begin
      m_done <= 0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1; m_quo <= p_quo; m_rem <= p_rem; m_dbz <= 0;
        end
      end else if (!m_done && start) begin
        if (divisor == 0) begin
          m_done <= 1; m_quo <= 16'hFFFF; m_rem <= dividend; m_dbz <= 1;
        end else begin
          m_left <= 16;
          p_quo  <= dividend / divisor;
          p_rem  <= dividend % divisor;
        end
      end
    end
  end

  // Every cycle outside reset, all outputs must match the model.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      chk("busy", busy, m_left > 0);
      chk("done", done, m_done);
      chk("quotient", quotient, m_quo);
      chk("remainder", remainder, m_rem);
      chk("div_by_zero", div_by_zero, m_dbz);
      if (busy && done) chk("busy_and_done", 1, 0);
    end
  end

  always @(posedge clk) if (done) done_cnt++;

  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic run_lit(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er, input bit edbz);
    launch(a, b);
    wait_done();
    chk("lit_quotient", quotient, eq);
    chk("lit_remainder", remainder, er);
    chk("lit_dbz", div_by_zero, edbz);
    @(negedge clk);
  endtask

  initial begin
    int d0;
    logic [15:0] a, b;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Basic divide: done exactly 16 cycles of busy after the accepting edge.
    launch(16'd100, 16'd7);
    chk("basic_busy", busy, 1);
    begin
      int bc = 1;
      while (busy && bc < 40) begin @(negedge clk); if (busy) bc++; end
      chk("basic_busy_cycles", bc, 16);
      chk("basic_done", done, 1);
    end
    chk("basic_quotient", quotient, 14);
    chk("basic_remainder", remainder, 2);
    chk("model_quotient", m_quo, 14);
    @(negedge clk);

    run_lit(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
    run_lit(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);
    run_lit(16'd3, 16'd10, 16'd0, 16'd3, 1'b0);

    // Divide by zero: done right after the accepting edge, busy stays low.
    launch(16'd1234, 16'd0);
    chk("dbz_done_latency", done, 1);
    chk("dbz_busy", busy, 0);
    chk("dbz_quotient", quotient, 16'hFFFF);
    chk("dbz_remainder", remainder, 1234);
    chk("dbz_flag", div_by_zero, 1);
    @(negedge clk);
    run_lit(16'd9, 16'd3, 16'd3, 16'd0, 1'b0);

    // A start during RUN is ignored.
    d0 = done_cnt;
    launch(16'd50, 16'd5);
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 16'd77; divisor = 16'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("busy_start_quotient", quotient, 10);
    chk("busy_start_remainder", remainder, 0);
    repeat (20) @(negedge clk);
    chk("busy_start_done_pulses", done_cnt - d0, 1);

    // Reset mid-run aborts immediately and suppresses done.
    d0 = done_cnt;
    launch(16'd1000, 16'd3);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    run_lit(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);

    // Start held high: back-to-back acceptance, tracked by the model.
    @(negedge clk);
    start = 1'b1; dividend = 16'd40000; divisor = 16'd123;
    repeat (40) @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);

    // Random regression.
    for (int i = 0; i < 2500; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'($urandom_range(1, 15));
        1: b = 16'($urandom_range(1, 255));
        2: b = 16'($urandom_range(32768, 65535));
        default: b = 16'($urandom_range(1, 65535));
      endcase
      launch(a, b);
      wait_done();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
